// File: rtl/riscv_mpsoc_pkg.sv
// Shared AHB-Lite constants and UART transmitter types for the MPSoC MMIO slaves.
package riscv_mpsoc_pkg;

  // AHB transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB response codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // UART transmitter register offsets from UART_BASE
  localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

  // Serializer states
  typedef enum logic [1:0] {
    UART_IDLE  = 2'b00,
    UART_START = 2'b01,
    UART_DATA  = 2'b10,
    UART_STOP  = 2'b11
  } uart_tx_state_t;

  // True for transfer types that carry a real address phase
  function automatic logic is_xfer_trans(input logic [1:0] htrans);
    logic result;
    case (htrans)
      HTRANS_NONSEQ: result = 1'b1;
      HTRANS_SEQ:    result = 1'b1;
      default:       result = 1'b0;
    endcase
    return result;
  endfunction

  // STATUS register layout: level[15:8], busy[2], empty[1], full[0]
  function automatic logic [31:0] uart_status_word(input logic [7:0] level,
                                                   input logic       busy,
                                                   input logic       empty,
                                                   input logic       full);
    return {16'h0000, level, 5'b00000, busy, empty, full};
  endfunction

endpackage

// File: rtl/riscv_mmio_fifo.sv
// Synchronous FIFO with occupancy level; DEPTH must be a power of two so the
// pointers wrap naturally. Pushes when full and pops when empty are ignored.
module riscv_mmio_fifo
  import riscv_mpsoc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the registered occupancy
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  // Storage array and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
    end else if (pop_ok_s) begin
      rd_ptr_r <= rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy level; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = (level_r == LW'(DEPTH));
  assign empty    = (level_r == '0);
  assign level    = level_r;

endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// AHB-Lite MMIO buffered UART transmitter. CPU byte writes to TXDATA are queued
// in a small FIFO and sent 8N1 on uart_txd; a write to a full FIFO is held with
// wait states until the serializer frees an entry. STATUS exposes level/busy/
// empty/full with zero wait states.
module riscv_mmio_uart_tx
  import riscv_mpsoc_pkg::*;
#(
  parameter int                    HDATA_SIZE = 32,
  parameter int                    HADDR_SIZE = 32,
  parameter logic [HADDR_SIZE-1:0] UART_BASE  = 32'h8000_1080,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    BAUD_DIV   = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  uart_txd,
  output logic                  tx_empty
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  // Address decode
  logic [HADDR_SIZE-1:0] ofs_s;
  logic                  addr_valid_s;
  logic                  hit_txdata_s;
  logic                  hit_status_s;

  // Pending data phase
  logic dp_tx_write_r;
  logic dp_status_read_r;

  // FIFO interface
  logic             push_s;
  logic             pop_s;
  logic [7:0]       fifo_rdata_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [LVL_W-1:0] fifo_level_s;

  // Serializer
  uart_tx_state_t   state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             txd_r;
  logic             busy_s;
  logic             baud_last_s;

  logic [HDATA_SIZE-1:0] rdata_s;
  logic                  unused_s;

  // Only the low byte of the write data and the decoded offsets matter
  assign unused_s = ^{HSIZE, HBURST, HWDATA[HDATA_SIZE-1:8]};

  // Decode the address phase against the two word-aligned register offsets
  always_comb begin
    ofs_s        = HADDR - UART_BASE;
    addr_valid_s = HSEL & is_xfer_trans(HTRANS);
    hit_txdata_s = addr_valid_s & (ofs_s == HADDR_SIZE'(UART_TXDATA_OFS));
    hit_status_s = addr_valid_s & (ofs_s == HADDR_SIZE'(UART_STATUS_OFS));
  end

  // Capture the address phase when the bus is ready; a completed push retires
  // a pending TXDATA write even if the bus is held elsewhere
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_tx_write_r    <= 1'b0;
      dp_status_read_r <= 1'b0;
    end else if (HREADY) begin
      dp_tx_write_r    <= hit_txdata_s & HWRITE;
      dp_status_read_r <= hit_status_s & ~HWRITE;
    end else if (push_s) begin
      dp_tx_write_r    <= 1'b0;
      dp_status_read_r <= dp_status_read_r;
    end else begin
      dp_tx_write_r    <= dp_tx_write_r;
      dp_status_read_r <= dp_status_read_r;
    end
  end

  // Push when the registered level shows space; otherwise stall the data phase
  always_comb begin
    push_s = dp_tx_write_r & ~fifo_full_s;
  end

  riscv_mmio_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .push      (push_s),
    .push_data (HWDATA[7:0]),
    .pop       (pop_s),
    .pop_data  (fifo_rdata_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // Serializer bookkeeping shared by the pop request and the FSM
  always_comb begin
    busy_s      = (state_r != UART_IDLE);
    baud_last_s = (baud_cnt_r == BAUD_LAST);
  end

  // Pop a byte when idle, or at the end of a stop bit for a gapless next frame
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      UART_IDLE: pop_s = ~fifo_empty_s;
      UART_STOP: pop_s = baud_last_s & ~fifo_empty_s;
      default:   pop_s = 1'b0;
    endcase
  end

  // Serializer FSM: start bit, 8 data bits LSB first, stop bit; line level is
  // registered from the current state so it trails the state by one cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r    <= UART_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      txd_r      <= 1'b1;
    end else begin
      case (state_r)
        UART_START: txd_r <= 1'b0;
        UART_DATA:  txd_r <= shift_r[0];
        default:    txd_r <= 1'b1;
      endcase

      case (state_r)
        UART_IDLE: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          if (pop_s) begin
            shift_r <= fifo_rdata_s;
            state_r <= UART_START;
          end
        end
        UART_START: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            state_r    <= UART_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            shift_r    <= {1'b0, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= UART_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            if (pop_s) begin
              shift_r <= fifo_rdata_s;
              state_r <= UART_START;
            end else begin
              state_r <= UART_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          state_r    <= UART_IDLE;
        end
      endcase
    end
  end

  // Read data for the current data phase; only STATUS returns non-zero
  always_comb begin
    rdata_s = '0;
    if (dp_status_read_r) begin
      rdata_s = HDATA_SIZE'(uart_status_word(8'(fifo_level_s), busy_s,
                                             fifo_empty_s, fifo_full_s));
    end else begin
      rdata_s = '0;
    end
  end

  assign HRDATA    = rdata_s;
  assign HREADYOUT = ~(dp_tx_write_r & fifo_full_s);
  assign HRESP     = HRESP_OKAY;
  assign uart_txd  = txd_r;
  assign tx_empty  = fifo_empty_s & ~busy_s;

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed bench for riscv_mmio_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_riscv_mmio_uart_tx;
  import riscv_mpsoc_pkg::*;

  localparam int          BD   = 4;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'h8000_1080;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        uart_txd;
  logic        tx_empty;
  logic        hready_block;

  int checks = 0;
  int errors = 0;
  logic rec [320];

  // Bus-level ready: this slave's ready unless another slave is modelled stalling
  assign HREADY = hready_block ? 1'b0 : HREADYOUT;

  always #5 HCLK = ~HCLK;

  riscv_mmio_uart_tx #(
    .HDATA_SIZE (32),
    .HADDR_SIZE (32),
    .UART_BASE  (BASE),
    .FIFO_DEPTH (FD),
    .BAUD_DIV   (BD)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HTRANS    (HTRANS),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .uart_txd  (uart_txd),
    .tx_empty  (tx_empty)
  );

  // Expected line level for bit b of a frame carrying d
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    else if (b == 9) return 1'b1;
    else return d[b-1];
  endfunction

  // One AHB transfer: address phase, then data phase until HREADYOUT
  task automatic bus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic wr, input logic [31:0] wdata, input logic block_addr,
                     output logic [31:0] rdata, output int stalls);
    @(posedge HCLK); #1;
    HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; hready_block = block_addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0; HWRITE = 1'b0;
    HWDATA = wdata; hready_block = 1'b0;
    stalls = 0;
    @(negedge HCLK);
    while (!HREADYOUT && stalls < 200) begin
      stalls++;
      @(negedge HCLK);
    end
    rdata = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge HCLK);
    while (!tx_empty && n < 1000) begin
      n++;
      @(negedge HCLK);
    end
    checks++;
    if (tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_timeout tx_empty=%b expected 1", name, tx_empty);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int st;
    HRESET = 1'b1;
    #12;
    checks++;
    if ({HREADYOUT, HRDATA, uart_txd, tx_empty, HRESP} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b rdata=%h txd=%b empty=%b resp=%b expected 1 0 1 1 0",
               HREADYOUT, HRDATA, uart_txd, tx_empty, HRESP);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus(1'b1, HTRANS_NONSEQ, BASE + 32'h4, 1'b0, 32'h0, 1'b0, rd, st);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL reset_status got %h expected 00000002", rd);
    end
  endtask

  task automatic test_frame_0x41();
    logic [31:0] rd;
    int st;
    bus(1'b1, HTRANS_NONSEQ, BASE, 1'b1, 32'hFFFF_FF41, 1'b0, rd, st);
    @(negedge HCLK);
    checks++;
    if (uart_txd !== 1'b1 || tx_empty !== 1'b0) begin
      errors++;
      $display("FAIL frame41_accept txd=%b empty=%b expected 1 0", uart_txd, tx_empty);
    end
    @(negedge HCLK);
    checks++;
    if (uart_txd !== 1'b1) begin
      errors++;
      $display("FAIL frame41_latency txd=%b expected 1", uart_txd);
    end
    for (int k = 0; k < 10 * BD; k++) begin
      @(negedge HCLK);
      checks++;
      if (uart_txd !== frame_bit(8'h41, k / BD)) begin
        errors++;
        $display("FAIL frame41_bit cycle %0d txd=%b expected %b", k, uart_txd, frame_bit(8'h41, k / BD));
      end
    end
    checks++;
    if (tx_empty !== 1'b1 || uart_txd !== 1'b1) begin
      errors++;
      $display("FAIL frame41_done empty=%b txd=%b expected 1 1", tx_empty, uart_txd);
    end
  endtask

  task automatic test_status_midframe();
    logic [31:0] rd;
    int st;
    bus(1'b1, HTRANS_NONSEQ, BASE, 1'b1, 32'h55, 1'b0, rd, st);
    bus(1'b1, HTRANS_NONSEQ, BASE, 1'b1, 32'hAA, 1'b0, rd, st);
    bus(1'b1, HTRANS_NONSEQ, BASE + 32'h4, 1'b0, 32'h0, 1'b0, rd, st);
    checks++;
    if (rd !== 32'h0000_0104 || st !== 0) begin
      errors++;
      $display("FAIL status_midframe got %h stalls %0d expected 00000104 stalls 0", rd, st);
    end
    wait_idle("status_midframe");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    int stall6;
    int s;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    stall6 = -1;
    fork
      begin
        logic [31:0] rd;
        int st;
        for (int w = 0; w < 6; w++) begin
          bus(1'b1, HTRANS_NONSEQ, BASE, 1'b1, {24'h0, bytes[w]}, 1'b0, rd, st);
          if (w == 5) stall6 = st;
        end
      end
      begin
        for (int i = 0; i < 320; i++) begin
          @(negedge HCLK);
          rec[i] = uart_txd;
        end
      end
    join
    // first byte goes straight to the shifter, four fill the FIFO, the sixth
    // waits until frame one's stop bit ends and pops the next byte
    checks++;
    if (stall6 !== 27) begin
      errors++;
      $display("FAIL b2b_stall got %0d wait cycles expected 27", stall6);
    end
    s = -1;
    for (int i = 0; i < 80; i++) begin
      if (s < 0 && rec[i] === 1'b0) s = i;
    end
    checks++;
    if (s < 0) begin
      errors++;
      $display("FAIL b2b_start no start bit seen, expected one");
    end else begin
      for (int f = 0; f < 6; f++) begin
        for (int b = 0; b < 10; b++) begin
          logic ok;
          ok = 1'b1;
          for (int c = 0; c < BD; c++) begin
            if (rec[s + f * 40 + b * BD + c] !== frame_bit(bytes[f], b)) ok = 1'b0;
          end
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL b2b_frame %0d bit %0d got %b expected %b", f, b,
                     rec[s + f * 40 + b * BD], frame_bit(bytes[f], b));
          end
        end
      end
      checks++;
      if (rec[s + 240] !== 1'b1 || tx_empty !== 1'b1) begin
        errors++;
        $display("FAIL b2b_end txd=%b empty=%b expected 1 1", rec[s + 240], tx_empty);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int st;
    bus(1'b1, HTRANS_NONSEQ, BASE, 1'b1, 32'hF0, 1'b0, rd, st);
    bus(1'b1, HTRANS_NONSEQ, BASE, 1'b1, 32'h0F, 1'b0, rd, st);
    repeat (15) @(posedge HCLK);
    #2;
    checks++;
    if (uart_txd !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bit3 txd=%b expected 0", uart_txd);
    end
    HRESET = 1'b1;
    #1;
    checks++;
    if (uart_txd !== 1'b1 || tx_empty !== 1'b1 || HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async txd=%b empty=%b rdy=%b expected 1 1 1", uart_txd, tx_empty, HREADYOUT);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus(1'b1, HTRANS_NONSEQ, BASE + 32'h4, 1'b0, 32'h0, 1'b0, rd, st);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL rstmid_status got %h expected 00000002", rd);
    end
    repeat (5) @(negedge HCLK);
    checks++;
    if (uart_txd !== 1'b1 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_flushed txd=%b empty=%b expected 1 1", uart_txd, tx_empty);
    end
  endtask

  task automatic test_ignored();
    logic        sel   [7];
    logic [1:0]  trans [7];
    logic [31:0] addr  [7];
    logic        blk   [7];
    logic        exp_e [7];
    logic [31:0] rd;
    int st;
    sel   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    trans = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_NONSEQ,
              HTRANS_NONSEQ, HTRANS_NONSEQ, HTRANS_SEQ};
    addr  = '{BASE, BASE, BASE, BASE + 32'h8, BASE, BASE + 32'h4, BASE};
    blk   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 7; v++) begin
      bus(sel[v], trans[v], addr[v], 1'b1, 32'h5A, blk[v], rd, st);
      repeat (3) @(negedge HCLK);
      checks++;
      if (tx_empty !== exp_e[v] || st !== 0 || HRESP !== 1'b0) begin
        errors++;
        $display("FAIL ignored_case %0d empty=%b stalls=%0d resp=%b expected %b 0 0",
                 v, tx_empty, st, HRESP, exp_e[v]);
      end
    end
    wait_idle("ignored_seq");
    bus(1'b1, HTRANS_NONSEQ, BASE, 1'b0, 32'h0, 1'b0, rd, st);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL txdata_read got %h expected 00000000", rd);
    end
    bus(1'b1, HTRANS_NONSEQ, BASE + 32'h8, 1'b0, 32'h0, 1'b0, rd, st);
    checks++;
    if (rd !== 32'h0 || st !== 0) begin
      errors++;
      $display("FAIL unmapped_read got %h stalls %0d expected 00000000 stalls 0", rd, st);
    end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0; HWRITE = 1'b0;
    HSIZE = 3'b000; HBURST = 3'b000; HWDATA = 32'h0; hready_block = 1'b0;
    test_reset();
    test_frame_0x41();
    test_status_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
